// File: rtl/regmux_n.sv
// NCH:1 channel mux feeding a 2-entry skid FIFO; each word carries its source channel as a tag.
// Optional build macro REGMUX_SELCHK_EN: block out-of-range selects and raise a sticky sel_err.
module regmux_n #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int SELW  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [SELW-1:0]      in_sel,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_tag,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef REGMUX_SELCHK_EN
   ,output logic                 sel_err
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                      state, state_nxt;
    logic                        rdy_ok;
    logic                        push, pop;
    logic                        ld_head, ld_skid, shift;
    logic                        sel_oor;
    logic [NCH-1:0]              sel_hit;
    logic [NCH-1:0]              lane_push;
    logic [NCH-1:0][WIDTH-1:0]   lane_masked;
    logic [WIDTH-1:0]            mux_data;
    logic [WIDTH-1:0]            head_data, skid_data;
    logic [SELW-1:0]             head_tag, skid_tag;

    assign sel_oor = 32'(in_sel) >= NCH;

    // Per-channel decode: a channel only sees ready when it is the selected one.
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign sel_hit[k]     = (in_sel == SELW'(k));
        assign lane_masked[k] = in_data[k*WIDTH +: WIDTH] & {WIDTH{sel_hit[k]}};
        assign in_ready[k]    = sel_hit[k] & rdy_ok;
        assign lane_push[k]   = in_valid[k] & in_ready[k];
    end

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NCH; k++)
            mux_data |= lane_masked[k];
    end

    // An out-of-range select matches no lane, so mux_data is 0 in that case.
    always_comb begin
        push = |lane_push;
`ifndef REGMUX_SELCHK_EN
        if (sel_oor)
            push = (|in_valid) & rdy_ok;
`endif
    end

    assign pop = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (!push && pop) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Ready and valid come only from state, so ready never sees out_ready combinationally.
    always_comb begin
        out_valid = (state == ONE) || (state == FULL);
        rdy_ok    = (state != FULL);
        ld_head   = push && ((state == EMPTY) || (state == ONE && pop));
        ld_skid   = push && (state == ONE) && !pop;
        shift     = pop && (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_data <= '0;
            head_tag  <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            if (ld_head) begin
                head_data <= mux_data;
                head_tag  <= in_sel;
            end else if (shift) begin
                head_data <= skid_data;
                head_tag  <= skid_tag;
            end
            if (ld_skid) begin
                skid_data <= mux_data;
                skid_tag  <= in_sel;
            end
        end
    end

    assign out_data = head_data;
    assign out_tag  = head_tag;

`ifdef REGMUX_SELCHK_EN
    always_ff @(posedge clk) begin
        if (rst)
            sel_err <= 1'b0;
        else if (sel_oor)
            sel_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_regmux_n.sv
// Directed bench for regmux_n: a 4-channel instance for FIFO behaviour and a
// 3-channel instance for out-of-range select handling (either build of REGMUX_SELCHK_EN).
module tb_regmux_n;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [4*W-1:0] a_data;
    logic [3:0]     a_valid, a_ready;
    logic [1:0]     a_sel, a_tag;
    logic [W-1:0]   a_odata;
    logic           a_ovalid, a_oready;

    // 3-channel instance
    logic [3*W-1:0] b_data;
    logic [2:0]     b_valid, b_ready;
    logic [1:0]     b_sel, b_tag;
    logic [W-1:0]   b_odata;
    logic           b_ovalid, b_oready;
`ifdef REGMUX_SELCHK_EN
    logic           b_err;
`endif

    regmux_n #(.WIDTH(W), .NCH(4), .SELW(2)) u_a (
        .clk(clk), .rst(rst),
        .in_data(a_data), .in_valid(a_valid), .in_sel(a_sel), .in_ready(a_ready),
        .out_data(a_odata), .out_tag(a_tag), .out_valid(a_ovalid), .out_ready(a_oready)
    );

    regmux_n #(.WIDTH(W), .NCH(3), .SELW(2)) u_b (
        .clk(clk), .rst(rst),
        .in_data(b_data), .in_valid(b_valid), .in_sel(b_sel), .in_ready(b_ready),
        .out_data(b_odata), .out_tag(b_tag), .out_valid(b_ovalid), .out_ready(b_oready)
`ifdef REGMUX_SELCHK_EN
       ,.sel_err(b_err)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        a_data   = '0;
        a_valid  = 4'hF;
        a_sel    = 2'd0;
        a_oready = 1'b1;
        b_data   = '0;
        b_valid  = 3'b000;
        b_sel    = 2'd0;
        b_oready = 1'b1;

        // Reset cycle with all valids high: nothing gets in.
        a_data[0 +: W] = 32'h1234_5678;
        tick();
        chk("rst_ovalid", a_ovalid, 1'b0);
        chk("rst_odata",  a_odata,  32'h0);
        chk("rst_otag",   a_tag,    2'd0);
        rst     = 1'b0;
        a_valid = 4'h0;
        settle();
        chk("post_rst_ready", a_ready, 4'b0001);

        // Basic push on channel 2, one-cycle latency.
        a_data[2*W +: W] = 32'hDEAD_BEEF;
        a_sel   = 2'd2;
        a_valid = 4'b0100;
        settle();
        chk("basic_ready_pre", a_ready, 4'b0100);
        tick();
        a_valid = 4'h0;
        settle();
        chk("basic_ovalid", a_ovalid, 1'b1);
        chk("basic_odata",  a_odata,  32'hDEAD_BEEF);
        chk("basic_otag",   a_tag,    2'd2);
        chk("basic_ready",  a_ready,  4'b0100);
        tick();
        chk("basic_drain", a_ovalid, 1'b0);

        // Backpressure: A, B fill the buffer, C waits upstream.
        a_oready = 1'b0;
        a_sel    = 2'd1;
        a_valid  = 4'b0010;
        a_data[1*W +: W] = 32'hAAAA_0001;
        tick();
        a_data[1*W +: W] = 32'hBBBB_0002;
        tick();
        a_data[1*W +: W] = 32'hCCCC_0003;
        settle();
        chk("bp_full_ready", a_ready, 4'b0000);
        chk("bp_head_a",     a_odata, 32'hAAAA_0001);
        tick();
        chk("bp_hold_data",  a_odata, 32'hAAAA_0001);
        chk("bp_hold_tag",   a_tag,   2'd1);
        chk("bp_hold_ready", a_ready, 4'b0000);
        a_oready = 1'b1;
        tick();
        chk("bp_out_b", a_odata, 32'hBBBB_0002);
        chk("bp_ready_one", a_ready, 4'b0010);
        tick();
        a_valid = 4'h0;
        settle();
        chk("bp_out_c",  a_odata,  32'hCCCC_0003);
        chk("bp_c_vld",  a_ovalid, 1'b1);
        tick();
        chk("bp_empty",  a_ovalid, 1'b0);

        // Streaming: alternate ch0/ch1, one word per cycle.
        for (int i = 0; i < 8; i++) begin
            a_sel = 2'(i % 2);
            a_data[(i % 2)*W +: W] = 32'h5000_0000 + i;
            a_valid = 4'(1 << (i % 2));
            settle();
            chk($sformatf("str_ready%0d", i), a_ready, 4'(1 << (i % 2)));
            tick();
            chk($sformatf("str_data%0d", i), a_odata, 32'h5000_0000 + i);
            chk($sformatf("str_tag%0d", i),  a_tag,   2'(i % 2));
        end
        a_valid = 4'h0;
        tick();
        chk("str_empty", a_ovalid, 1'b0);

        // Mid-operation reset from FULL.
        a_oready = 1'b0;
        a_sel    = 2'd3;
        a_valid  = 4'b1000;
        a_data[3*W +: W] = 32'h0A0A_0A0A;
        tick();
        a_data[3*W +: W] = 32'h0B0B_0B0B;
        tick();
        a_valid = 4'h0;
        settle();
        chk("mr_full_ready", a_ready, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_oready = 1'b1;
        settle();
        chk("mr_ovalid", a_ovalid, 1'b0);
        chk("mr_odata",  a_odata,  32'h0);
        chk("mr_ready",  a_ready,  4'b1000);
        tick();
        chk("mr_no_ab",  a_ovalid, 1'b0);

        // Out-of-range select on the 3-channel instance.
        b_sel   = 2'd3;
        b_valid = 3'b111;
        b_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        settle();
        chk("oor_ready", b_ready, 3'b000);
        tick();
        b_valid = 3'b000;
`ifdef REGMUX_SELCHK_EN
        settle();
        chk("oor_no_push", b_ovalid, 1'b0);
        chk("oor_err",     b_err,    1'b1);
        b_sel = 2'd1;
        b_valid = 3'b010;
        tick();
        b_valid = 3'b000;
        chk("oor_err_held", b_err,   1'b1);
        chk("oor_then_ok",  b_odata, 32'h2222_2222);
        chk("oor_then_tag", b_tag,   2'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("oor_err_clr", b_err,    1'b0);
        chk("oor_rst_vld", b_ovalid, 1'b0);
`else
        settle();
        chk("oor_push_vld",  b_ovalid, 1'b1);
        chk("oor_push_data", b_odata,  32'h0);
        chk("oor_push_tag",  b_tag,    2'd3);
        b_sel = 2'd1;
        b_valid = 3'b010;
        tick();
        b_valid = 3'b000;
        chk("oor_then_ok",  b_odata, 32'h2222_2222);
        chk("oor_then_tag", b_tag,   2'd1);
        tick();
        chk("oor_drain", b_ovalid, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
